// File: rtl/enreg_write_arbiter_pkg.sv
// Shared definitions for the enable-gated register write arbiter:
// FSM state encodings and state width.
package enreg_write_arbiter_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_GRANT = 2'd1;
  localparam logic [ST_W-1:0] ST_WRITE = 2'd2;
  localparam logic [ST_W-1:0] ST_ACK   = 2'd3;

endpackage

// File: rtl/en_storage_reg.sv
// WIDTH-bit storage register that loads d only when en is high.
// Asynchronous active-high reset clears the contents to zero.
module en_storage_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load on enable, otherwise hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/enreg_write_arbiter.sv
// Round-robin arbiter sharing one enable-gated register among N_REQ
// requesters. Each transaction walks IDLE -> GRANT -> WRITE -> ACK and
// performs exactly one register write; a requester that drops req while
// in GRANT aborts without writing and without advancing the pointer.
module enreg_write_arbiter
  import enreg_write_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic                   reg_en,
  output logic [WIDTH-1:0]       reg_d,
  output logic [WIDTH-1:0]       q,
  output logic                   busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [ST_W-1:0]  state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             reg_en_q, reg_en_d;
  logic [WIDTH-1:0] reg_d_q, reg_d_d;
  logic [IW-1:0]    win;
  logic [IW-1:0]    ptr_nxt;

  // First asserted request scanning p, p+1, ... mod N_REQ. Iterating from the
  // farthest offset down lets the nearest one overwrite the selection.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [IW-1:0]    p);
    logic [IW-1:0] sel;
    int            j;
    sel = p;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(p) + k) % N_REQ;
      if (r[j]) sel = IW'(j);
    end
    return sel;
  endfunction

  assign win     = rr_pick(req, ptr_q);
  assign ptr_nxt = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;

  // Next-state logic for the handshake FSM and its output registers.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    ack_d    = ack_q;
    reg_en_d = 1'b0;
    reg_d_d  = reg_d_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          idx_d      = win;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (req[idx_q]) begin
          reg_en_d = 1'b1;
          reg_d_d  = wdata[int'(idx_q)*WIDTH +: WIDTH];
          state_d  = ST_WRITE;
        end else begin
          // Requester withdrew: no write, pointer left where it was.
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        // Write commits this edge regardless of req.
        ack_d        = '0;
        ack_d[idx_q] = 1'b1;
        ptr_d        = ptr_nxt;
        state_d      = ST_ACK;
      end
      ST_ACK: begin
        ack_d   = '0;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        ack_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      reg_en_q <= 1'b0;
      reg_d_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      reg_en_q <= reg_en_d;
      reg_d_q  <= reg_d_d;
    end
  end

  en_storage_reg #(.WIDTH(WIDTH)) u_store (
    .clock (clock),
    .reset (reset),
    .en    (reg_en_q),
    .d     (reg_d_q),
    .q     (q)
  );

  assign gnt    = gnt_q;
  assign ack    = ack_q;
  assign reg_en = reg_en_q;
  assign reg_d  = reg_d_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_enreg_write_arbiter.sv
// Directed bench for enreg_write_arbiter (N_REQ=4, WIDTH=8).
module tb_enreg_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clock;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt, ack;
  logic           reg_en;
  logic [W-1:0]   reg_d, q;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;

  enreg_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .wdata  (wdata),
    .gnt    (gnt),
    .ack    (ack),
    .reg_en (reg_en),
    .reg_d  (reg_d),
    .q      (q),
    .busy   (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           en;
    logic [W-1:0]   q;
    logic           busy;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [N-1:0] eg, input logic [N-1:0] ea,
                         input logic een, input logic [W-1:0] eq, input logic eb);
    chk({nm, ".gnt"},    32'(gnt),    32'(eg));
    chk({nm, ".ack"},    32'(ack),    32'(ea));
    chk({nm, ".reg_en"}, 32'(reg_en), 32'(een));
    chk({nm, ".q"},      32'(q),      32'(eq));
    chk({nm, ".busy"},   32'(busy),   32'(eb));
  endtask

  initial begin
    logic [N*W-1:0] rr_data;
    logic [W-1:0]   qexp;
    int             o;

    // single req[2] (ptr=1 after round robin), then wrap case from ptr=3
    tbl[0] = '{4'b0100, 32'h00A50000, 4'b0100, 4'b0000, 1'b0, 8'h10, 1'b1};
    tbl[1] = '{4'b0100, 32'h00A50000, 4'b0100, 4'b0000, 1'b1, 8'h10, 1'b1};
    tbl[2] = '{4'b0100, 32'h00A50000, 4'b0100, 4'b0100, 1'b0, 8'hA5, 1'b1};
    tbl[3] = '{4'b0000, 32'h00A50000, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b0};
    tbl[4] = '{4'b0101, 32'h00220011, 4'b0001, 4'b0000, 1'b0, 8'hA5, 1'b1};
    tbl[5] = '{4'b0101, 32'h00220011, 4'b0001, 4'b0000, 1'b1, 8'hA5, 1'b1};
    tbl[6] = '{4'b0101, 32'h00220011, 4'b0001, 4'b0001, 1'b0, 8'h11, 1'b1};
    tbl[7] = '{4'b0000, 32'h00220011, 4'b0000, 4'b0000, 1'b0, 8'h11, 1'b0};

    reset = 1'b1;
    req   = '0;
    wdata = '0;
    tick();
    tick();
    chk_all("reset", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
    chk("reset.reg_d", 32'(reg_d), 32'h0);
    reset = 1'b0;
    tick();
    chk_all("idle_norq", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);

    // All four requesting continuously: grants 0,1,2,3,0 every 4 cycles
    rr_data = 32'h13121110;
    req     = 4'b1111;
    wdata   = rr_data;
    qexp    = 8'h00;
    for (int k = 0; k < 5; k++) begin
      o = k % N;
      tick();
      chk_all($sformatf("rr%0d.grant", k), 4'(1 << o), 4'b0000, 1'b0, qexp, 1'b1);
      tick();
      chk_all($sformatf("rr%0d.write", k), 4'(1 << o), 4'b0000, 1'b1, qexp, 1'b1);
      chk($sformatf("rr%0d.reg_d", k), 32'(reg_d), 32'(rr_data[o*W +: W]));
      qexp = rr_data[o*W +: W];
      tick();
      chk_all($sformatf("rr%0d.ack", k), 4'(1 << o), 4'(1 << o), 1'b0, qexp, 1'b1);
      tick();
      chk_all($sformatf("rr%0d.idle", k), 4'b0000, 4'b0000, 1'b0, qexp, 1'b0);
    end
    req = '0;

    // Table: single req[2] then wrap from ptr=3 to req[0]
    for (int i = 0; i < 8; i++) begin
      req   = tbl[i].req;
      wdata = tbl[i].wdata;
      tick();
      chk_all($sformatf("tbl%0d", i), tbl[i].gnt, tbl[i].ack, tbl[i].en, tbl[i].q, tbl[i].busy);
    end

    // Abort in GRANT: req[1] dropped, no write, ptr stays at 1
    req   = 4'b0010;
    wdata = 32'h0000EE00;
    tick();
    chk_all("abort.grant", 4'b0010, 4'b0000, 1'b0, 8'h11, 1'b1);
    req = 4'b0000;
    tick();
    chk_all("abort.idle", 4'b0000, 4'b0000, 1'b0, 8'h11, 1'b0);
    tick();
    chk_all("abort.hold", 4'b0000, 4'b0000, 1'b0, 8'h11, 1'b0);
    req = 4'b1010;
    tick();
    chk("abort.ptr_kept", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    chk_all("abort2.idle", 4'b0000, 4'b0000, 1'b0, 8'h11, 1'b0);

    // Drop req[3] while in WRITE: write still commits
    req   = 4'b1000;
    wdata = 32'h77000000;
    tick();
    chk_all("drop.grant", 4'b1000, 4'b0000, 1'b0, 8'h11, 1'b1);
    tick();
    chk_all("drop.write", 4'b1000, 4'b0000, 1'b1, 8'h11, 1'b1);
    req = 4'b0000;
    tick();
    chk_all("drop.ack", 4'b1000, 4'b1000, 1'b0, 8'h77, 1'b1);
    tick();
    chk_all("drop.idle", 4'b0000, 4'b0000, 1'b0, 8'h77, 1'b0);

    // Reset mid-WRITE: everything clears at once, q stays 0
    req   = 4'b0010;
    wdata = 32'h00005A00;
    tick();
    chk("rstw.grant", 32'(gnt), 32'h2);
    tick();
    chk("rstw.in_write", 32'(reg_en), 32'h1);
    reset = 1'b1;
    #1;
    chk_all("rstw.async", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
    chk("rstw.reg_d", 32'(reg_d), 32'h0);
    tick();
    chk_all("rstw.held", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    req   = 4'b0011;
    wdata = 32'h00005A33;
    tick();
    chk_all("rstw.regrant", 4'b0001, 4'b0000, 1'b0, 8'h00, 1'b1);
    req = 4'b0000;
    tick();
    chk_all("rstw.abort", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
